// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and code formula for the keypad scanner
package keypad_pkg;

    localparam int KEY_CODE_W = 8;
    localparam logic [KEY_CODE_W-1:0] KEY_NONE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAND = 2'd1,
        ST_HELD = 2'd2
    } deb_state_t;

    // Code 0 is reserved for "no key", so codes start at 1.
    function automatic logic [KEY_CODE_W-1:0] key_code_of(input int col_i, input int row_i,
                                                          input int num_rows);
        return KEY_CODE_W'(col_i * num_rows + row_i + 1);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - synchronous FIFO holding debounced key codes
module key_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with frame debounce and key-code FIFO
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [NUM_COLS-1:0]   col,
    input  logic [NUM_ROWS-1:0]   row,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    input  logic                  key_read_ack,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0]         dwell_cnt;
    logic [IW-1:0]         col_idx;
    logic [NUM_COLS-1:0]   col_q;
    logic [KEY_CODE_W-1:0] acc;
    logic [KEY_CODE_W-1:0] col_low;
    logic [KEY_CODE_W-1:0] merged;
    logic [KEY_CODE_W-1:0] frame_code;
    logic                  frame_done;
    logic                  sample;
    logic                  last_col;

    deb_state_t            state, state_n;
    logic [KEY_CODE_W-1:0] cand, cand_n;
    logic [DW-1:0]         cnt, cnt_n;
    logic [DW-1:0]         rel, rel_n;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [KEY_CODE_W-1:0] fifo_head;

    assign sample   = (dwell_cnt == CW'(SCAN_DIV - 1));
    assign last_col = (col_idx == IW'(NUM_COLS - 1));
    assign col      = col_q;

    // Lowest pressed row in the driven column; scanning high to low lets the lowest win.
    always_comb begin
        col_low = KEY_NONE;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row[r]) col_low = key_code_of(int'(col_idx), r, NUM_ROWS);
        end
    end

    // Columns are visited in rising order, so the first code seen in a frame is the lowest.
    assign merged = (acc != KEY_NONE) ? acc : col_low;

    // Dwell counter, column rotation and per-frame accumulation of the lowest code.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dwell_cnt  <= '0;
            col_idx    <= '0;
            col_q      <= ~NUM_COLS'(1);
            acc        <= KEY_NONE;
            frame_code <= KEY_NONE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sample) begin
                dwell_cnt <= '0;
                if (last_col) begin
                    col_idx    <= '0;
                    col_q      <= ~NUM_COLS'(1);
                    acc        <= KEY_NONE;
                    frame_code <= merged;
                    frame_done <= 1'b1;
                end else begin
                    col_idx <= col_idx + 1'b1;
                    col_q   <= ~(NUM_COLS'(1) << (col_idx + 1'b1));
                    acc     <= merged;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cand  <= KEY_NONE;
            cnt   <= '0;
            rel   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
            rel   <= rel_n;
        end
    end

    // Debounce next state, advanced once per committed frame result.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        rel_n   = rel;
        if (frame_done) begin
            case (state)
                ST_IDLE: begin
                    if (frame_code != KEY_NONE) begin
                        cand_n  = frame_code;
                        cnt_n   = DW'(1);
                        rel_n   = '0;
                        state_n = (DEBOUNCE == 1) ? ST_HELD : ST_CAND;
                    end
                end
                ST_CAND: begin
                    if (frame_code == KEY_NONE) begin
                        state_n = ST_IDLE;
                    end else if (frame_code == cand) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == DW'(DEBOUNCE)) begin
                            state_n = ST_HELD;
                            rel_n   = '0;
                        end
                    end else begin
                        cand_n = frame_code;
                        cnt_n  = DW'(1);
                    end
                end
                ST_HELD: begin
                    if (frame_code == cand) begin
                        rel_n = '0;
                    end else begin
                        rel_n = rel + 1'b1;
                        if (rel_n == DW'(DEBOUNCE)) state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Debounce output: a push on the frame that confirms a press.
    always_comb begin
        push = 1'b0;
        if (frame_done && frame_code != KEY_NONE) begin
            if (state == ST_IDLE && DEBOUNCE == 1) push = 1'b1;
            if (state == ST_CAND && frame_code == cand && cnt == DW'(DEBOUNCE - 1)) push = 1'b1;
        end
    end

    assign pop = key_read_ack && !fifo_empty;

    key_fifo #(
        .WIDTH (KEY_CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (frame_code),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign key_valid = !fifo_empty;
    assign key_code  = fifo_empty ? KEY_NONE : fifo_head;

    // Sticky drop flag; a fresh drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int DIV   = 4;
    localparam int DEB   = 3;
    localparam int DEPTH = 2;
    localparam int FRAME = NR * DIV;

    logic          clk;
    logic          reset;
    logic [NC-1:0] col;
    logic [NR-1:0] row;
    logic [7:0]    key_code;
    logic          key_valid;
    logic          key_read_ack;
    logic          overflow;
    logic          clear_overflow;

    logic [15:0]   keys;
    int            total;
    int            bad;

    logic [7:0]    mq[$];
    logic          m_ovf;
    logic [7:0]    pending;
    int            held_key;
    int            run_key;
    int            run_len;
    int            rel_len;

    keypad_scanner #(
        .NUM_ROWS   (NR),
        .NUM_COLS   (NC),
        .SCAN_DIV   (DIV),
        .DEBOUNCE   (DEB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .col            (col),
        .row            (row),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .key_read_ack   (key_read_ack),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when that column is low.
    always_comb begin
        row = '1;
        for (int c = 0; c < NC; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < NR; r++) begin
                    if (keys[c*NR + r]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, 32'(key_valid), 32'(mq.size() != 0));
        check({tag, "_code"}, 32'(key_code), 32'((mq.size() != 0) ? mq[0] : 8'h00));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    function automatic int lowest_code(input logic [15:0] k);
        for (int i = 0; i < 16; i++) begin
            if (k[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        pending  = 8'h00;
        held_key = 0;
        run_key  = 0;
        run_len  = 0;
        rel_len  = 0;
    endtask

    // Run-length view of debounce: a press needs DEB equal nonzero frames, a release DEB unequal ones.
    task automatic model_frame(input int f);
        pending = 8'h00;
        if (held_key != 0) begin
            if (f == held_key) begin
                rel_len = 0;
            end else begin
                rel_len++;
                if (rel_len == DEB) begin
                    held_key = 0;
                    run_key  = 0;
                    run_len  = 0;
                end
            end
        end else if (f == 0) begin
            run_key = 0;
            run_len = 0;
        end else begin
            if (f == run_key) begin
                run_len++;
            end else begin
                run_key = f;
                run_len = 1;
            end
            if (run_len == DEB) begin
                held_key = f;
                rel_len  = 0;
                pending  = 8'(f);
            end
        end
    endtask

    // One whole frame, entered just after the previous commit edge (or reset release).
    task automatic run_frame(input logic [15:0] k, input int nack, input bit ack_first, input bit clr);
        int used;
        keys         = k;
        key_read_ack = ack_first;
        @(posedge clk);
        if (ack_first && mq.size() > 0) void'(mq.pop_front());
        if (pending != 8'h00) begin
            if (mq.size() < DEPTH) mq.push_back(pending);
            else m_ovf = 1'b1;
            pending = 8'h00;
        end
        @(negedge clk);
        key_read_ack = 1'b0;
        check_outputs("post_commit");
        used = 1;
        for (int i = 0; i < nack; i++) begin
            key_read_ack = 1'b1;
            @(posedge clk);
            if (mq.size() > 0) void'(mq.pop_front());
            @(negedge clk);
            key_read_ack = 1'b0;
            check_outputs("after_ack");
            used++;
        end
        if (clr) begin
            clear_overflow = 1'b1;
            @(posedge clk);
            m_ovf = 1'b0;
            @(negedge clk);
            clear_overflow = 1'b0;
            check("ovf_clear", 32'(overflow), 32'(m_ovf));
            used++;
        end
        for (int e = used + 1; e <= FRAME; e++) begin
            @(posedge clk);
            if (e == 9) begin
                @(negedge clk);
                check("col_mid", 32'(col), 32'(4'hF & ~(4'b0001 << ((e / DIV) % NC))));
            end
        end
        @(negedge clk);
        model_frame(lowest_code(k));
        check_outputs("at_commit");
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_frame(k, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] rk;
        int          span;
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        keys           = '0;
        key_read_ack   = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", 32'(col), 32'(4'b1110));
        check_outputs("rst");
        reset = 1'b1;

        // Single key held for six frames: one push of 02.
        hold(16'h0002, 6);
        run_frame(16'h0000, 1, 1'b0, 1'b0);
        hold(16'h0000, 2);

        // Bouncing key: the gap restarts the count.
        hold(16'h0004, 2);
        hold(16'h0000, 1);
        hold(16'h0004, 3);
        run_frame(16'h0000, 0, 1'b1, 1'b0);
        hold(16'h0000, 2);

        // Two keys at once: the lower code (05) wins over 0C.
        hold(16'h0810, 3);
        run_frame(16'h0000, 1, 1'b0, 1'b0);
        hold(16'h0000, 2);

        // Three presses without reading: third is dropped and overflow sticks.
        hold(16'h0001, 3);
        hold(16'h0000, 3);
        hold(16'h0020, 3);
        hold(16'h0000, 3);
        hold(16'h8000, 3);
        hold(16'h0000, 3);
        run_frame(16'h0000, 2, 1'b0, 1'b0);
        run_frame(16'h0000, 0, 1'b0, 1'b1);

        // Full FIFO with a read on the same edge as the next push: nothing lost.
        hold(16'h0001, 3);
        hold(16'h0000, 3);
        hold(16'h0020, 3);
        hold(16'h0000, 3);
        hold(16'h8000, 3);
        run_frame(16'h0000, 0, 1'b1, 1'b0);
        run_frame(16'h0000, 2, 1'b0, 1'b0);
        hold(16'h0000, 1);

        // Reset in the middle of a candidate run.
        hold(16'h0040, 3);
        hold(16'h0000, 3);
        hold(16'h0001, 2);
        keys = 16'h0001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check("midrst_col", 32'(col), 32'(4'b1110));
        check_outputs("midrst");
        reset = 1'b1;
        hold(16'h0001, 4);
        run_frame(16'h0000, 1, 1'b0, 1'b0);
        hold(16'h0000, 2);

        // Random key patterns, each held a random number of frames, with random reads.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       rk = 16'h0000;
                3:       rk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: rk = 16'h0001 << $urandom_range(0, 15);
            endcase
            span = int'($urandom_range(1, 5));
            for (int f = 0; f < span; f++) begin
                run_frame(rk, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
